// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter giving NUM_CORES ld/st ports access to one single-port shared memory.
// One transaction in flight; all outputs registered; ld and st together are served as a load.
module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        mem_req_ld,
  input  logic [NUM_CORES-1:0]        mem_req_st,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        val_data,
  output logic [NUM_CORES*DATA_W-1:0] mem_dat,
  output logic                        sm_en,
  output logic                        sm_we,
  output logic [ADDR_W-1:0]           sm_addr,
  output logic [DATA_W-1:0]           sm_wdata,
  input  logic [DATA_W-1:0]           sm_rdata,
  output logic                        busy,
  output logic [3:0]                  grant_id,
  output logic                        err_ldst
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]           state_reg;
  logic [PW-1:0]        rr_reg;
  logic [PW-1:0]        id_reg;
  logic [NUM_CORES-1:0] val_data_reg;
  logic                 sm_en_reg;
  logic                 sm_we_reg;
  logic [ADDR_W-1:0]    sm_addr_reg;
  logic [DATA_W-1:0]    sm_wdata_reg;
  logic                 busy_reg;
  logic [3:0]           grant_id_reg;
  logic                 err_ldst_reg;
  logic [DATA_W-1:0]    mem_dat_reg [NUM_CORES];

  logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]    wdata_arr [NUM_CORES];
  logic [NUM_CORES-1:0] eligible;
  logic                 found;
  logic [PW-1:0]        win_id;
  logic [PW:0]          sum;
  logic [PW-1:0]        rr_next;
  logic [NUM_CORES-1:0] id_onehot;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign addr_arr[gi]  = core_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = core_wdata[gi*DATA_W +: DATA_W];
      assign mem_dat[gi*DATA_W +: DATA_W] = mem_dat_reg[gi];

      // Read data is valid in RDWAIT, the cycle after the SM read strobe.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_dat_reg[gi] <= '0;
        end else if (state_reg == S_RDWAIT && id_reg == PW'(gi)) begin
          mem_dat_reg[gi] <= sm_rdata;
        end
      end
    end
  endgenerate

  // Masking val_data keeps a core whose request falls with its pulse from winning again.
  assign eligible = (mem_req_ld | mem_req_st) & ~val_data_reg;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, rr_reg} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_CORES)) sum = sum - (PW+1)'(NUM_CORES);
      if (!found && eligible[sum[PW-1:0]]) begin
        found  = 1'b1;
        win_id = sum[PW-1:0];
      end
    end
  end

  assign rr_next   = (id_reg == PW'(NUM_CORES-1)) ? '0 : id_reg + 1'b1;
  assign id_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << id_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      rr_reg       <= '0;
      id_reg       <= '0;
      val_data_reg <= '0;
      sm_en_reg    <= 1'b0;
      sm_we_reg    <= 1'b0;
      sm_addr_reg  <= '0;
      sm_wdata_reg <= '0;
      busy_reg     <= 1'b0;
      grant_id_reg <= '0;
      err_ldst_reg <= 1'b0;
    end else begin
      if (|(mem_req_ld & mem_req_st)) err_ldst_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (found) begin
            state_reg    <= S_ACCESS;
            id_reg       <= win_id;
            grant_id_reg <= 4'(win_id);
            busy_reg     <= 1'b1;
            sm_en_reg    <= 1'b1;
            sm_we_reg    <= ~mem_req_ld[win_id];
            sm_addr_reg  <= addr_arr[win_id];
            sm_wdata_reg <= wdata_arr[win_id];
          end
        end
        S_ACCESS: begin
          sm_en_reg <= 1'b0;
          sm_we_reg <= 1'b0;
          if (sm_we_reg) begin
            state_reg    <= S_RESP;
            val_data_reg <= id_onehot;
          end else begin
            state_reg <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          state_reg    <= S_RESP;
          val_data_reg <= id_onehot;
        end
        default: begin
          state_reg    <= S_IDLE;
          val_data_reg <= '0;
          busy_reg     <= 1'b0;
          rr_reg       <= rr_next;
        end
      endcase
    end
  end

  assign val_data = val_data_reg;
  assign sm_en    = sm_en_reg;
  assign sm_we    = sm_we_reg;
  assign sm_addr  = sm_addr_reg;
  assign sm_wdata = sm_wdata_reg;
  assign busy     = busy_reg;
  assign grant_id = grant_id_reg;
  assign err_ldst = err_ldst_reg;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural single-port SM (read data = addr[7:0]^0x5A
// until written).
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  mem_req_ld, mem_req_st;
  logic [47:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  val_data;
  logic [31:0] mem_dat;
  logic        sm_en, sm_we;
  logic [11:0] sm_addr;
  logic [7:0]  sm_wdata;
  logic [7:0]  sm_rdata;
  logic        busy;
  logic [3:0]  grant_id;
  logic        err_ldst;
  logic        mem_init;
  logic [7:0]  smem [0:4095];

  int errors = 0;
  int checks = 0;

  shared_mem_arbiter #(.NUM_CORES(4), .ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_ld(mem_req_ld), .mem_req_st(mem_req_st),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .val_data(val_data), .mem_dat(mem_dat),
    .sm_en(sm_en), .sm_we(sm_we), .sm_addr(sm_addr), .sm_wdata(sm_wdata),
    .sm_rdata(sm_rdata),
    .busy(busy), .grant_id(grant_id), .err_ldst(err_ldst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) smem[i] <= 8'(i) ^ 8'h5A;
      sm_rdata <= 8'h00;
    end else if (sm_en) begin
      if (sm_we) smem[sm_addr] <= sm_wdata;
      else       sm_rdata <= smem[sm_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int c, input logic [11:0] a, input logic [7:0] d);
    core_addr[c*12 +: 12] = a;
    core_wdata[c*8 +: 8]  = d;
  endtask

  // Waits for the completion pulse (bounded) and checks latency, target and grant id.
  task automatic run_txn(input string tag, input int core, input int exp_lat);
    int lat = 0;
    while (val_data == 4'b0000 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_val"}, {28'd0, val_data}, {28'd0, oh(core)});
    check({tag, "_gid"}, {28'd0, grant_id}, core);
    $display("txn %s core=%0d lat=%0d val_data=%b grant_id=%0d mem_dat=%h err_ldst=%b",
             tag, core, lat, val_data, grant_id, mem_dat, err_ldst);
  endtask

  initial begin
    int seen;
    reset_n    = 1'b0;
    mem_init   = 1'b1;
    mem_req_ld = '0;
    mem_req_st = '0;
    core_addr  = '0;
    core_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_val", {28'd0, val_data}, 0);
    check("rst_memdat", mem_dat, 0);
    check("rst_sm", {19'd0, sm_en, sm_we, sm_addr}, 0);
    check("rst_wdata", {24'd0, sm_wdata}, 0);
    check("rst_busy_gid_err", {26'd0, busy, grant_id, err_ldst}, 0);
    mem_init = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);

    // reset mid-load aborts without a pulse
    set_core(0, 12'h005, 8'h00);
    mem_req_ld[0] = 1'b1;
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {26'd0, busy, sm_en, sm_we, val_data}, 0);
    mem_req_ld = '0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (val_data != 0 || busy) seen++;
    end
    check("abort_no_val", seen, 0);
    $display("txn abort core=0 val_data=%b busy=%b", val_data, busy);

    // single store from core2
    set_core(2, 12'h123, 8'hA5);
    mem_req_st[2] = 1'b1;
    @(negedge clk);
    check("st_access", {14'd0, sm_en, sm_we, sm_addr, busy, grant_id}, {14'd0, 1'b1, 1'b1, 12'h123, 1'b1, 4'd2});
    check("st_wdata", {24'd0, sm_wdata}, 32'hA5);
    check("st_no_early_val", {28'd0, val_data}, 0);
    run_txn("st", 2, 1);
    check("st_sm_en_low", {31'd0, sm_en}, 0);
    mem_req_st[2] = 1'b0;
    @(negedge clk);
    check("st_idle", {27'd0, busy, val_data}, 0);

    // load back from core2; later address changes must not matter
    mem_req_ld[2] = 1'b1;
    @(negedge clk);
    check("ld_access", {18'd0, sm_en, sm_we, sm_addr}, {18'd0, 1'b1, 1'b0, 12'h123});
    set_core(2, 12'h456, 8'h00);
    run_txn("ld", 2, 2);
    check("ld_data", {24'd0, mem_dat[23:16]}, 32'hA5);
    mem_req_ld[2] = 1'b0;
    @(negedge clk);

    // rr pointer is 3: only core0 asks, withdraws after grant, still completes
    set_core(0, 12'h010, 8'h00);
    mem_req_ld[0] = 1'b1;
    @(negedge clk);
    check("wrap_gid", {28'd0, grant_id}, 0);
    mem_req_ld[0] = 1'b0;
    run_txn("wrap", 0, 2);
    check("wrap_data", {24'd0, mem_dat[7:0]}, 32'h4A);
    @(negedge clk);
    // pointer now 1: core2 beats core0
    mem_req_ld[0] = 1'b1;
    mem_req_ld[2] = 1'b1;
    @(negedge clk);
    check("rr_after_wrap", {28'd0, grant_id}, 2);
    run_txn("rr_after_wrap", 2, 2);
    mem_req_ld = '0;
    check("ld_data_replaced", {24'd0, mem_dat[23:16]}, 32'h0C);
    @(negedge clk);

    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst2_memdat", mem_dat, 0);

    // fairness: all four hold loads
    for (int i = 0; i < 4; i++) set_core(i, 12'h200 + 12'(i), 8'h00);
    mem_req_ld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_txn("fair", k % 4, 3);
      if (k < 4) @(negedge clk);
    end
    mem_req_ld = '0;
    check("fair_data", mem_dat, {8'h59, 8'h58, 8'h5B, 8'h5A});
    @(negedge clk);

    // core1 drops on its pulse: no second grant
    mem_req_ld[1] = 1'b1;
    run_txn("drop", 1, 3);
    mem_req_ld[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || val_data != 0) seen++;
    end
    check("drop_no_regrant", seen, 0);

    // ld+st together on core3: served as load, sticky error
    set_core(3, 12'h300, 8'h77);
    mem_req_ld[3] = 1'b1;
    mem_req_st[3] = 1'b1;
    run_txn("ldst", 3, 3);
    mem_req_ld[3] = 1'b0;
    mem_req_st[3] = 1'b0;
    check("ldst_data", {24'd0, mem_dat[31:24]}, 32'h5A);
    repeat (4) @(negedge clk);
    check("ldst_err_sticky", {31'd0, err_ldst}, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("ldst_err_cleared", {31'd0, err_ldst}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
